usb3_scramble_lanes: RTL

Parametrised USB 3.0 data scrambler for the PIPE transmit and receive paths: processes `BYTES` symbols per clock using polynomial x^16+x^5+x^4+x^3+1.
- Applies the USB 3.0 symbol rules per byte lane: COM reseeds the LFSR, SKP freezes it, other K-symbols pass unscrambled, data bytes are scrambled.
- Scrambling is its own inverse, so the same block serves both directions. It sits between the link-layer framer and the PIPE interface, replacing the fixed 32-bit, data-only scrambler.

---
 rtl/usb3_scramble_lanes.sv | 105 ++++++++++
 1 files changed

// File: rtl/usb3_scramble_lanes.sv
// USB 3.0 symbol scrambler (x^16+x^5+x^4+x^3+1, Galois form), BYTES symbols per beat.
// Self-inverse, so one instance serves either the transmit or the receive path.

module usb3_scramble_lane #(
    parameter logic [15:0] SEED = 16'hFFFF
) (
    input  logic [15:0] i_lfsr,
    input  logic [7:0]  i_data,
    input  logic        i_k,
    input  logic        i_scram_en,
    output logic [15:0] o_lfsr,
    output logic [7:0]  o_data
);
    // Returns {keystream byte, LFSR after eight bit steps}; bit 0 is the first keystream bit.
    function automatic logic [23:0] byte_step(input logic [15:0] s);
        logic [15:0] st;
        logic [7:0]  ks;
        st = s;
        ks = '0;
        for (int i = 0; i < 8; i++) begin
            ks[i] = st[15];
            st    = {st[14:0], 1'b0} ^ (st[15] ? 16'h0039 : 16'h0000);
        end
        return {ks, st};
    endfunction

    logic [23:0] w_step;
    logic        w_is_com;
    logic        w_is_skp;

    assign w_step   = byte_step(i_lfsr);
    assign w_is_com = i_k && (i_data == 8'hBC);
    assign w_is_skp = i_k && (i_data == 8'h3C);

    always_comb begin
        o_data = i_data;
        o_lfsr = w_step[15:0];
        if (w_is_com) begin
            o_lfsr = SEED;
        end else if (w_is_skp) begin
            o_lfsr = i_lfsr;
        end else if (!i_k && i_scram_en) begin
            o_data = i_data ^ w_step[23:16];
        end
    end
endmodule

module usb3_scramble_lanes #(
    parameter int          BYTES = 4,
    parameter logic [15:0] SEED  = 16'hFFFF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [8*BYTES-1:0]   in_data,
    input  logic [BYTES-1:0]     in_k,
    input  logic                 scram_en,
    input  logic                 scram_rst,
    output logic                 out_valid,
    output logic [8*BYTES-1:0]   out_data,
    output logic [BYTES-1:0]     out_k,
    output logic [15:0]          lfsr_state
);
    logic [15:0]              r_lfsr;
    logic                     r_out_valid;
    logic [8*BYTES-1:0]       r_out_data;
    logic [BYTES-1:0]         r_out_k;
    logic [BYTES:0][15:0]     w_chain;
    logic [BYTES-1:0][7:0]    w_data;

    // scram_rst reseeds ahead of lane 0 even on idle cycles.
    assign w_chain[0] = scram_rst ? SEED : r_lfsr;

    for (genvar g = 0; g < BYTES; g++) begin : g_lane
        usb3_scramble_lane #(.SEED(SEED)) u_lane (
            .i_lfsr     (w_chain[g]),
            .i_data     (in_data[8*g +: 8]),
            .i_k        (in_k[g]),
            .i_scram_en (scram_en),
            .o_lfsr     (w_chain[g+1]),
            .o_data     (w_data[g])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lfsr      <= SEED;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_k     <= '0;
        end else begin
            r_lfsr      <= in_valid ? w_chain[BYTES] : w_chain[0];
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_out_data <= w_data;
                r_out_k    <= in_k;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_k      = r_out_k;
    assign lfsr_state = r_lfsr;
endmodule
